fetch_sequencer: RTL

Controller that drives newPC into the fetch stage every cycle and qualifies what the fetch stage produces. It owns the architectural fetch PC and selects among four next-PC sources: sequential (+1), branch redirect, hold (stall or memory wait) and halt. It emits valid/bubble qualifiers so decode can squash wrong-path or held instructions. It sits between hazard/branch logic and the fetch stage.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_wait_counter.sv | 36 +++
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the fetch sequencer
package fetch_pkg;

    localparam int PC_W_DEF   = 24;
    localparam int ADDR_W_DEF = 16;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STALL = 3'd3,
        ST_FLUSH = 3'd4,
        ST_HALT  = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/fetch_wait_counter.sv
// rtl/fetch_wait_counter.sv - loadable down-counter shared by memory-wait and flush timing
module fetch_wait_counter import fetch_pkg::*; #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // load wins over enable so a restart can happen in the same cycle as a count
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - owns the fetch PC, picks the next-PC source and qualifies fetch output
module fetch_sequencer import fetch_pkg::*; #(
    parameter int              PC_W         = PC_W_DEF,
    parameter int              ADDR_W       = ADDR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              MEM_WAIT     = 0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    output logic [PC_W-1:0] newPC,
    output logic            fetch_valid,
    output logic            bubble,
    output logic            oob_fault,
    output logic [2:0]      state
);

    localparam bit         HAS_WAIT   = (MEM_WAIT > 0);
    localparam logic [2:0] WAIT_LOAD  = 3'(HAS_WAIT ? MEM_WAIT - 1 : 0);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    fetch_state_t    state_q, state_d, ret_q, ret_d, eff_state;
    logic [PC_W-1:0] pc_q, pc_d, cand_pc;
    logic            fv_q, fv_d, bubble_q, bubble_d, oob_q, oob_d;
    logic            cnt_load, cnt_en, cnt_zero, issue, oob_hit;
    logic [2:0]      cnt_val;

    fetch_wait_counter #(.W(3)) u_wait_cnt (
        .clk      (CLK),
        .rst_n    (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        // once stall drops, STALL behaves as the state it interrupted in the same cycle
        eff_state = (state_q == ST_STALL && !stall) ? ret_q : state_q;
        state_d   = state_q;
        ret_d     = ret_q;
        cand_pc   = pc_q;
        fv_d      = 1'b0;
        oob_d     = oob_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_en    = 1'b0;
        issue     = 1'b0;

        if (state_q == ST_HALT || halt) begin
            state_d = ST_HALT;
        end else if (redirect) begin
            cand_pc  = redirect_pc;
            state_d  = ST_FLUSH;
            cnt_load = 1'b1;
            cnt_val  = FLUSH_LOAD;
        end else if (stall && state_q != ST_FLUSH) begin
            if (state_q != ST_STALL) begin
                ret_d = state_q;
            end
            state_d = ST_STALL;
        end else begin
            case (eff_state)
                ST_BOOT: issue = 1'b1;
                ST_RUN: begin
                    cand_pc = pc_q + 1'b1;
                    issue   = 1'b1;
                end
                ST_WAIT: begin
                    state_d = ST_WAIT;
                    if (cnt_zero) begin
                        state_d = ST_RUN;
                        fv_d    = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    cnt_en = 1'b1;
                    if (!stall) begin
                        cand_pc = pc_q + 1'b1;
                    end
                    if (cnt_zero) begin
                        if (stall) begin
                            state_d = ST_RUN;
                        end else begin
                            issue = 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // a freshly presented address is either complete now or must sit out the memory wait
            if (issue) begin
                if (HAS_WAIT) begin
                    state_d  = ST_WAIT;
                    cnt_load = 1'b1;
                    cnt_val  = WAIT_LOAD;
                end else begin
                    state_d = ST_RUN;
                    fv_d    = 1'b1;
                end
            end
        end

        oob_hit = (state_q != ST_HALT) && ((cand_pc >> ADDR_W) != '0);
        pc_d    = cand_pc;
        if (oob_hit) begin
            pc_d     = pc_q;
            oob_d    = 1'b1;
            state_d  = ST_HALT;
            fv_d     = 1'b0;
            cnt_load = 1'b0;
        end
        if (!rst) begin
            pc_d = RESET_PC;
        end
        bubble_d = ~fv_d;
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_BOOT;
            ret_q    <= ST_RUN;
            pc_q     <= RESET_PC;
            fv_q     <= 1'b0;
            bubble_q <= 1'b1;
            oob_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            pc_q     <= pc_d;
            fv_q     <= fv_d;
            bubble_q <= bubble_d;
            oob_q    <= oob_d;
        end
    end

    assign newPC       = pc_d;
    assign fetch_valid = fv_q;
    assign bubble      = bubble_q;
    assign oob_fault   = oob_q;
    assign state       = state_q;

endmodule
